// File: rtl/lvds_pkg.sv
// Shared constants and types for the 7:1 LVDS serializer.
// No ports; imported by lvds_ser7_tx and its bench.
package lvds_pkg;

  localparam int LVDS_WORD_W = 7;
  localparam logic [6:0] LVDS_IDLE_PAT = 7'b1100011;
  localparam int LVDS_UFLOW_W = 16;

  typedef logic [6:0] lvds_word_t;

endpackage

// File: rtl/lvds_ser7_tx.sv
// 7:1 serializer: hold register + shift register, idle fill on underflow,
// one-bit word-boundary slip. LSB of each word goes out first.
// Ports: clk, rst_n (sync, active-low), din/din_valid/din_ready,
//   bitslip, sdo, sdo_frame, uflow, uflow_cnt.
// Build option: LVDS_SER7_UFLOW_CNT_EN enables the saturating underflow
//   counter; without it uflow_cnt is tied to 0.
module lvds_ser7_tx
  import lvds_pkg::*;
#(
  parameter int WORD_W = LVDS_WORD_W,
  parameter logic [LVDS_WORD_W-1:0] IDLE_PAT = LVDS_IDLE_PAT,
  parameter int UFLOW_W = LVDS_UFLOW_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  din,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic               bitslip,
  output logic               sdo,
  output logic               sdo_frame,
  output logic               uflow,
  output logic [UFLOW_W-1:0] uflow_cnt
);

  localparam logic [2:0] LAST = 3'(WORD_W - 1);

  logic [WORD_W-1:0] r_sh;
  logic [2:0]        r_bit_cnt;
  logic [WORD_W-1:0] r_hold;
  logic              r_hold_vld;
  logic              r_uflow;

  logic w_load;
  logic w_accept;
  logic w_uf;

  // A slip cycle stretches the current bit, so it also defers the load.
  assign w_load   = (r_bit_cnt == LAST) && !bitslip;
  assign w_uf     = w_load && !r_hold_vld;
  assign din_ready = !r_hold_vld || w_load;
  assign w_accept = din_valid && din_ready;

  assign sdo       = r_sh[0];
  assign sdo_frame = (r_bit_cnt == 3'd0);
  assign uflow     = r_uflow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh       <= IDLE_PAT;
      r_bit_cnt  <= 3'd0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_uflow    <= 1'b0;
    end else begin
      r_uflow <= 1'b0;
      if (bitslip) begin
        r_sh      <= r_sh;
        r_bit_cnt <= r_bit_cnt;
      end else if (w_load) begin
        r_sh      <= r_hold_vld ? r_hold : IDLE_PAT;
        r_bit_cnt <= 3'd0;
        r_uflow   <= !r_hold_vld;
      end else begin
        r_sh      <= r_sh >> 1;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      // Accept wins over load-clear: the old word moves to sh,
      // the new word takes its place in hold.
      if (w_accept) begin
        r_hold     <= din;
        r_hold_vld <= 1'b1;
      end else if (w_load) begin
        r_hold_vld <= 1'b0;
      end
    end
  end

`ifdef LVDS_SER7_UFLOW_CNT_EN
  logic [UFLOW_W-1:0] r_uflow_cnt;

  // Counts on the same edge that raises uflow, so both move together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_uflow_cnt <= '0;
    end else if (w_uf && (r_uflow_cnt != '1)) begin
      r_uflow_cnt <= r_uflow_cnt + UFLOW_W'(1);
    end
  end

  assign uflow_cnt = r_uflow_cnt;
`else
  assign uflow_cnt = '0;
`endif

endmodule

// File: tb/tb_lvds_ser7_tx.sv
// Directed self-checking bench for lvds_ser7_tx.
// Tracks the expected bit position itself and compares every output bit.
module tb_lvds_ser7_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        bitslip;
  logic        sdo;
  logic        sdo_frame;
  logic        uflow;
  logic [15:0] uflow_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int pos = 0;

  localparam logic [6:0] IDLE = 7'b1100011;

`ifdef LVDS_SER7_UFLOW_CNT_EN
  localparam logic [15:0] CNT3 = 16'd3;
`else
  localparam logic [15:0] CNT3 = 16'd0;
`endif

  lvds_ser7_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .bitslip   (bitslip),
    .sdo       (sdo),
    .sdo_frame (sdo_frame),
    .uflow     (uflow),
    .uflow_cnt (uflow_cnt)
  );

  always #5 clk = ~clk;

  // One clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    logic slip;
    logic rs;
    slip = bitslip;
    rs = rst_n;
    @(posedge clk);
    #1;
    if (!rs) pos = 0;
    else if (!slip) pos = (pos == 6) ? 0 : pos + 1;
  endtask

  task automatic align(input int p);
    for (int i = 0; i < 8 && pos != p; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din = '0;
    din_valid = 1'b0;
    bitslip = 1'b0;
    step();
    step();
    n_cmp++;
    if (sdo !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_sdo got %b want 1", sdo);
    end
    n_cmp++;
    if (sdo_frame !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_frame got %b want 1", sdo_frame);
    end
    n_cmp++;
    if (din_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready got %b want 1", din_ready);
    end
    n_cmp++;
    if (uflow !== 1'b0 || uflow_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_uflow got %b/%h want 0/0", uflow, uflow_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 21; c++) begin
      n_cmp++;
      if (sdo !== IDLE[c % 7]) begin
        n_bad++;
        $display("FAIL idle_sdo c=%0d got %b want %b", c, sdo, IDLE[c % 7]);
      end
      n_cmp++;
      if (sdo_frame !== (c % 7 == 0)) begin
        n_bad++;
        $display("FAIL idle_frame c=%0d got %b", c, sdo_frame);
      end
      n_cmp++;
      if (uflow !== (c % 7 == 0 && c > 0)) begin
        n_bad++;
        $display("FAIL idle_uflow c=%0d got %b", c, uflow);
      end
      step();
    end
    n_cmp++;
    if (uflow !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_uflow_last got %b want 1", uflow);
    end
    n_cmp++;
    if (uflow_cnt !== CNT3) begin
      n_bad++;
      $display("FAIL idle_cnt got %h want %h", uflow_cnt, CNT3);
    end
  endtask

  task automatic test_single();
    logic [6:0] w;
    w = 7'h55;
    align(0);
    din = w;
    din_valid = 1'b1;
    n_cmp++;
    if (din_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_ready got %b want 1", din_ready);
    end
    step();
    din_valid = 1'b0;
    din = 7'h2A;
    for (int c = 1; c < 7; c++) begin
      n_cmp++;
      if (sdo !== IDLE[c]) begin
        n_bad++;
        $display("FAIL single_idle c=%0d got %b want %b", c, sdo, IDLE[c]);
      end
      if (c == 3) begin
        n_cmp++;
        if (din_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL single_busy got %b want 0", din_ready);
        end
      end
      step();
    end
    for (int c = 0; c < 7; c++) begin
      n_cmp++;
      if (sdo !== w[c]) begin
        n_bad++;
        $display("FAIL single_sdo c=%0d got %b want %b", c, sdo, w[c]);
      end
      n_cmp++;
      if (sdo_frame !== (c == 0)) begin
        n_bad++;
        $display("FAIL single_frame c=%0d got %b", c, sdo_frame);
      end
      n_cmp++;
      if (uflow !== 1'b0) begin
        n_bad++;
        $display("FAIL single_uflow c=%0d got %b want 0", c, uflow);
      end
      step();
    end
    n_cmp++;
    if (uflow !== 1'b1) begin
      n_bad++;
      $display("FAIL single_uflow_after got %b want 1", uflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] fr [5];
    logic [6:0] ws [3];
    int idx;
    logic exp_u;
    fr[0] = IDLE;
    fr[1] = 7'h01;
    fr[2] = 7'h7E;
    fr[3] = 7'h40;
    fr[4] = IDLE;
    ws[0] = 7'h01;
    ws[1] = 7'h7E;
    ws[2] = 7'h40;
    idx = 0;
    align(0);
    for (int c = 0; c < 29; c++) begin
      din_valid = (idx < 3);
      din = (idx < 3) ? ws[idx] : 7'h00;
      if (c <= 13) begin
        n_cmp++;
        if (din_ready !== (c == 0 || c == 6 || c == 13)) begin
          n_bad++;
          $display("FAIL b2b_ready c=%0d got %b", c, din_ready);
        end
      end
      n_cmp++;
      if (sdo !== fr[c / 7][c % 7]) begin
        n_bad++;
        $display("FAIL b2b_sdo c=%0d got %b want %b",
                 c, sdo, fr[c / 7][c % 7]);
      end
      exp_u = (c == 0 || c == 28);
      n_cmp++;
      if (uflow !== exp_u) begin
        n_bad++;
        $display("FAIL b2b_uflow c=%0d got %b want %b", c, uflow, exp_u);
      end
      if (din_valid && din_ready) idx++;
      step();
    end
    din_valid = 1'b0;
    n_cmp++;
    if (idx !== 3) begin
      n_bad++;
      $display("FAIL b2b_accepts got %0d want 3", idx);
    end
  endtask

  task automatic test_bitslip();
    logic [6:0] w;
    logic [8:0] es;
    logic [8:0] ef;
    w = 7'h2D;
    // bits out: 1,0,1,1,(1 again),0,1,0 then idle bit0 = 1
    es = {1'b1, w[6], w[5], w[4], w[3], w[3], w[2], w[1], w[0]};
    ef = 9'b1_0000_0001;
    align(0);
    din = w;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    align(0);
    for (int c = 0; c < 9; c++) begin
      bitslip = (c == 3);
      if (c == 3) begin
        n_cmp++;
        if (din_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL slip_ready got %b want 1", din_ready);
        end
      end
      n_cmp++;
      if (sdo !== es[c]) begin
        n_bad++;
        $display("FAIL slip_sdo c=%0d got %b want %b", c, sdo, es[c]);
      end
      n_cmp++;
      if (sdo_frame !== ef[c]) begin
        n_bad++;
        $display("FAIL slip_frame c=%0d got %b want %b", c, sdo_frame, ef[c]);
      end
      step();
      bitslip = 1'b0;
    end
  endtask

  task automatic test_uflow_sat();
    align(1);
`ifdef LVDS_SER7_UFLOW_CNT_EN
    force dut.r_uflow_cnt = 16'hFFFE;
    #1;
    release dut.r_uflow_cnt;
    align(0);
    n_cmp++;
    if (uflow !== 1'b1 || uflow_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL sat_reach got %b/%h want 1/ffff", uflow, uflow_cnt);
    end
    align(1);
    align(0);
    n_cmp++;
    if (uflow !== 1'b1 || uflow_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL sat_hold got %b/%h want 1/ffff", uflow, uflow_cnt);
    end
`else
    align(0);
    n_cmp++;
    if (uflow !== 1'b1 || uflow_cnt !== 16'h0000) begin
      n_bad++;
      $display("FAIL cnt_off got %b/%h want 1/0000", uflow, uflow_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    align(0);
    din = 7'h3C;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    align(4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if (sdo_frame !== 1'b1 || sdo !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_frame got %b/%b want 1/1", sdo_frame, sdo);
    end
    n_cmp++;
    if (din_ready !== 1'b1 || uflow_cnt !== 16'h0000) begin
      n_bad++;
      $display("FAIL rmid_state got %b/%h want 1/0000", din_ready, uflow_cnt);
    end
    for (int c = 0; c < 14; c++) begin
      n_cmp++;
      if (sdo !== IDLE[c % 7]) begin
        n_bad++;
        $display("FAIL rmid_sdo c=%0d got %b want %b", c, sdo, IDLE[c % 7]);
      end
      step();
    end
    n_cmp++;
    if (uflow !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_uflow got %b want 1", uflow);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_bitslip();
    test_uflow_sat();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
